// File: rtl/beam_sensor_qualifier.sv
// Sensor front end: two-flop sync, per-channel debounce with aborted-transition
// detection, sticky fault latches and a post-reset warm-up mask feeding the steering unit.
module beam_sensor_qualifier #(
    parameter int unsigned DB_CYC     = 4,
    parameter int unsigned WARMUP_CYC = 8,
    parameter logic [5:0]  LATCH_MASK = 6'b111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw_in,
    input  logic       latch_clr,
    output logic       A_xray,
    output logic       B_dose,
    output logic       C_pos,
    output logic       D_temp,
    output logic       E_vib,
    output logic       F_power,
    output logic       ready,
    output logic [5:0] glitch_flags,
    output logic [1:0] state_dbg
);

    localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYC - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'b00,
        ST_RUN    = 2'b01,
        ST_FAULT  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         sync1_q, sync2_q;
    logic [5:0]         filt_q, filt_d;
    logic [5:0][CW-1:0] cnt_q, cnt_d;
    logic [5:0]         lat_q, lat_d;
    logic [5:0]         glitch_q, glitch_d;
    logic [WW-1:0]      warm_q, warm_d;
    logic               ready_q, ready_d;
    logic [5:0]         flags;
    logic               latched_hot;

    // A transition only lands after DB_CYC consecutive disagreeing samples;
    // returning to agreement part-way through marks a glitch on that channel.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = '0;
        lat_d    = lat_q;
        glitch_d = latch_clr ? 6'b0 : glitch_q;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                if (cnt_q[i] != '0) begin
                    glitch_d[i] = 1'b1;
                end
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = ~filt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (LATCH_MASK[i]) begin
                if (filt_q[i] && (state_q != ST_WARMUP)) begin
                    lat_d[i] = 1'b1;
                end else if (latch_clr && !filt_q[i]) begin
                    lat_d[i] = 1'b0;
                end
            end else begin
                lat_d[i] = 1'b0;
            end
        end
    end

    assign flags       = (state_q == ST_WARMUP) ? 6'b0 : (filt_q | (lat_q & LATCH_MASK));
    assign latched_hot = |(flags & LATCH_MASK);

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        ready_d = ready_q;
        case (state_q)
            ST_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            ST_RUN: begin
                if (latched_hot) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (!latched_hot) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            glitch_q <= '0;
            warm_q   <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_WARMUP;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            glitch_q <= glitch_d;
            warm_q   <= warm_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
        end
    end

    assign A_xray       = flags[0];
    assign B_dose       = flags[1];
    assign C_pos        = flags[2];
    assign D_temp       = flags[3];
    assign E_vib        = flags[4];
    assign F_power      = flags[5];
    assign ready        = ready_q;
    assign glitch_flags = glitch_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_beam_sensor_qualifier.sv
// Bench for beam_sensor_qualifier: a directed vector table, hand-written corner
// sequences and a randomized run, all compared against a behavioural model.
module tb_beam_sensor_qualifier;

    localparam int         DB   = 4;
    localparam int         WU   = 8;
    localparam logic [5:0] MASK = 6'b111000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] raw_in;
    logic       latch_clr;
    logic       A_xray, B_dose, C_pos, D_temp, E_vib, F_power;
    logic       ready;
    logic [5:0] glitch_flags;
    logic [1:0] state_dbg;

    int vecCount  = 0;
    int missCount = 0;

    beam_sensor_qualifier #(
        .DB_CYC(DB),
        .WARMUP_CYC(WU),
        .LATCH_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .latch_clr(latch_clr),
        .A_xray(A_xray),
        .B_dose(B_dose),
        .C_pos(C_pos),
        .D_temp(D_temp),
        .E_vib(E_vib),
        .F_power(F_power),
        .ready(ready),
        .glitch_flags(glitch_flags),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] raw;
        logic       clr;
        logic       chk;
        logic [5:0] expFlags;
        logic       expReady;
        logic [5:0] expGlitch;
        logic [1:0] expState;
    } vec_t;

    vec_t vecs[$];

    // Reference model: raw-sample history, run lengths of disagreement and a warm-up edge count.
    logic [5:0] mHist[$];
    logic [5:0] mFilt, mLat, mGlitch;
    int         mRun[6];
    int         mWarm;
    logic       mFault;

    function automatic logic [5:0] modelOut();
        if (mWarm < WU) return 6'b0;
        return mFilt | (mLat & MASK);
    endfunction

    function automatic logic modelReady();
        return mWarm >= WU;
    endfunction

    function automatic logic [1:0] modelState();
        if (mWarm < WU) return 2'b00;
        return mFault ? 2'b10 : 2'b01;
    endfunction

    task automatic modelStep(input logic r, input logic [5:0] raw, input logic clr);
        logic [5:0] s, oldOut, nextFilt, newGlitch;
        bit warm;
        if (r) begin
            mHist = {6'd0, 6'd0};
            mFilt = '0; mLat = '0; mGlitch = '0; mWarm = 0; mFault = 1'b0;
            for (int i = 0; i < 6; i++) mRun[i] = 0;
            return;
        end
        oldOut    = modelOut();
        warm      = (mWarm < WU);
        s         = mHist[mHist.size() - 2];
        nextFilt  = mFilt;
        newGlitch = '0;
        for (int i = 0; i < 6; i++) begin
            if (s[i] == mFilt[i]) begin
                if (mRun[i] > 0) newGlitch[i] = 1'b1;
                mRun[i] = 0;
            end else if (mRun[i] + 1 >= DB) begin
                nextFilt[i] = ~mFilt[i];
                mRun[i] = 0;
            end else begin
                mRun[i]++;
            end
            if (MASK[i]) begin
                if (mFilt[i] && !warm) mLat[i] = 1'b1;
                else if (clr && !mFilt[i]) mLat[i] = 1'b0;
            end
        end
        mGlitch = (clr ? 6'b0 : mGlitch) | newGlitch;
        if (warm) mWarm++;
        else mFault = |(oldOut & MASK);
        mHist.push_back(raw);
        if (mHist.size() > 4) void'(mHist.pop_front());
        mFilt = nextFilt;
    endtask

    function automatic logic [5:0] dutFlags();
        return {F_power, E_vib, D_temp, C_pos, B_dose, A_xray};
    endfunction

    task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {14'd0, act}, {14'd0, exp});
    endtask

    task automatic applyStimulus(input logic r, input logic [5:0] raw, input logic clr);
        rst       = r;
        raw_in    = raw;
        latch_clr = clr;
        @(posedge clk);
        modelStep(r, raw, clr);
        @(negedge clk);
        checkOutput("model", {dutFlags(), ready, glitch_flags, state_dbg},
                    {modelOut(), modelReady(), mGlitch, modelState()});
    endtask

    task automatic addVec(input logic r, input logic [5:0] raw, input logic clr,
                          input logic [5:0] f, input logic rd, input logic [5:0] g,
                          input logic [1:0] st);
        vec_t v;
        v.rst = r; v.raw = raw; v.clr = clr; v.chk = 1'b1;
        v.expFlags = f; v.expReady = rd; v.expGlitch = g; v.expState = st;
        vecs.push_back(v);
    endtask

    initial begin
        logic [5:0] rawCur;
        rst = 1'b1; raw_in = '0; latch_clr = 1'b0;

        // Warm-up, debounce rise/fall on xray, then a two-cycle dose glitch cleared by latch_clr.
        for (int j = 0; j < 2; j++) addVec(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 2'b00);
        for (int e = 1; e <= 8; e++)
            addVec(1'b0, 6'd0, 1'b0, 6'd0, (e == 8), 6'd0, (e == 8) ? 2'b01 : 2'b00);
        for (int j = 0; j < 14; j++)
            addVec(1'b0, (j < 7) ? 6'd1 : 6'd0, 1'b0,
                   (j >= 5 && j < 12) ? 6'd1 : 6'd0, 1'b1, 6'd0, 2'b01);
        for (int g = 0; g < 10; g++)
            addVec(1'b0, (g < 2) ? 6'd2 : 6'd0, (g == 8), 6'd0, 1'b1,
                   (g >= 4 && g < 8) ? 6'd2 : 6'd0, 2'b01);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].raw, vecs[k].clr);
            if (vecs[k].chk)
                checkOutput("table", {dutFlags(), ready, glitch_flags, state_dbg},
                            {vecs[k].expFlags, vecs[k].expReady, vecs[k].expGlitch, vecs[k].expState});
        end

        // Temperature fault latch: held through raw fall and an early clear, released by a later clear.
        for (int t = 0; t < 20; t++) begin
            applyStimulus(1'b0, (t < 10) ? 6'd8 : 6'd0, (t == 12 || t == 16));
            if (t == 4)  checkBit("temp_before_debounce", D_temp, 1'b0);
            if (t == 5)  checkBit("temp_rise", D_temp, 1'b1);
            if (t == 5)  checkOutput("state_run_at_rise", {13'd0, state_dbg}, 15'd1);
            if (t == 6)  checkOutput("state_fault", {13'd0, state_dbg}, 15'd2);
            if (t == 12) checkBit("temp_clr_ignored", D_temp, 1'b1);
            if (t == 15) checkBit("temp_latched", D_temp, 1'b1);
            if (t == 16) checkBit("temp_cleared", D_temp, 1'b0);
            if (t == 16) checkOutput("state_still_fault", {13'd0, state_dbg}, 15'd2);
            if (t == 17) checkOutput("state_back_run", {13'd0, state_dbg}, 15'd1);
        end

        // Power present from reset is masked through warm-up, then drives a fault.
        applyStimulus(1'b1, 6'd32, 1'b0);
        applyStimulus(1'b1, 6'd32, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b0, 6'd32, 1'b0);
            checkBit("power_masked", F_power, (e == 8));
            checkBit("ready_warmup", ready, (e == 8));
        end
        applyStimulus(1'b0, 6'd32, 1'b0);
        checkOutput("power_fault", {13'd0, state_dbg}, 15'd2);
        for (int j = 0; j < 6; j++) applyStimulus(1'b0, (j < 2) ? 6'd33 : 6'd32, 1'b0);
        checkOutput("glitch_in_fault", {9'd0, glitch_flags}, 15'd1);

        // Reset mid-fault clears everything and restarts the warm-up count.
        applyStimulus(1'b1, 6'd32, 1'b0);
        checkOutput("reset_mid_fault", {dutFlags(), ready, glitch_flags, state_dbg}, 15'd0);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b0, 6'd32, 1'b0);
            checkBit("rewarm_ready", ready, (e == 8));
        end

        // Randomized channels toggling at varied rates, with occasional clears and resets.
        rawCur = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 6; i++)
                if ($urandom_range(0, 4) == 0) rawCur[i] = ~rawCur[i];
            applyStimulus(($urandom_range(0, 599) == 0), rawCur, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/beam_sensor_qualifier.md
Name: beam_sensor_qualifier

Overview:
Front-end conditioner that produces the six qualified condition flags (A_xray, B_dose, C_pos, D_temp, E_vib, F_power) consumed by the adaptive beam steering unit.
- Synchronises and debounces raw sensor lines.
- Latches safety faults until an operator clear.
- Masks all flags during a post-reset warm-up window.
- Sits between the raw sensor pins and the steering unit's condition inputs.

Parameters:
DB_CYC, 4, consecutive differing synchronised samples required to flip a filtered channel (>=1)
WARMUP_CYC, 8, cycles after reset release during which all flags are forced 0
LATCH_MASK, 6'b111000, per-bit select of sticky (fault-latched) channels, bit order as raw_in

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
raw_in  in  6  raw sensor lines; [0]xray [1]dose [2]pos [3]temp [4]vib [5]power
latch_clr  in  1  level, sampled each edge; clears released latches and glitch flags
A_xray, B_dose, C_pos, D_temp, E_vib, F_power  out  1 each  qualified flags = out[0..5]
ready  out  1  high once warm-up has completed
glitch_flags  out  6  sticky per-channel aborted-transition indicators
state_dbg  out  2  FSM state: 00 WARMUP, 01 RUN, 10 FAULT

Behaviour:
- Reset (rst=1 at an edge): sync flops, filt, cnt, lat, glitch_flags and warm-up counter all 0; state WARMUP. Hence all flags 0, ready 0, state_dbg 00. Reset mid-operation has the same effect and restarts warm-up.
- Synchroniser: two-flop chain per bit. s[i] is raw_in[i] delayed two edges.
- Debounce, per channel:
  - If s[i]==filt[i]: cnt[i]<=0.
  - Else if cnt[i]==DB_CYC-1: filt[i] flips, cnt[i]<=0.
  - Else: cnt[i]++.
  - Latency: a new raw level first sampled at edge k changes filt at edge k+DB_CYC+1 (k+5 at default).
- Glitch: if s[i]==filt[i] while cnt[i]!=0 (aborted transition), glitch_flags[i]<=1.
- Latch, for LATCH_MASK bits only:
  - lat[i]<=1 when filt[i]=1 and state!=WARMUP.
  - lat[i]<=0 when latch_clr=1 and filt[i]=0.
  - Set wins if both conditions hold in the same cycle.
  - latch_clr while filt[i]=1 has no effect on lat[i].
- latch_clr clears all glitch_flags in the same edge. A new glitch detected in that same cycle wins.
- Flag outputs are combinational from registers; no extra latency:
  - WARMUP: out[i]=0.
  - Otherwise, latched bit: out[i]=filt[i]|lat[i].
  - Otherwise, unlatched bit: out[i]=filt[i].
- FSM:
  - WARMUP→RUN on the WARMUP_CYC-th rising edge with rst=0; ready<=1 on that edge and stays 1 until reset.
  - RUN→FAULT when any latched-channel out is 1 (evaluated each edge).
  - FAULT→RUN when all latched-channel outs are 0.
- The debounce and sync paths run during WARMUP. A level present throughout warm-up therefore appears on the first RUN cycle, with no extra debounce delay.
- Unlatched channels never affect the FSM.

Test Plan:
1. Warm-up: rst=1 for 2 cycles, raw_in=0 → flags 0, ready 0 and state_dbg 00 for 8 edges; ready=1 and state_dbg=01 after the 8th edge post-release.
2. Debounce: in RUN, raw_in[0] 0→1 first sampled at edge k → A_xray rises at edge k+5; raw back to 0 at edge m → falls at m+5; glitch_flags stays 0.
3. Glitch: raw_in[1] high for 2 cycles only → B_dose stays 0, glitch_flags=6'b000010 until a latch_clr pulse returns it to 0.
4. Fault latch: raw_in[3] high for 10 cycles then low.
   - D_temp=1 and state_dbg=10 the edge after it rises.
   - D_temp stays 1 after raw falls.
   - latch_clr while filt[3]=1 → no change.
   - latch_clr after filt[3]=0 → D_temp=0 and lat[3] cleared that edge; state_dbg=01 the following edge.
5. Warm-up masking: raw_in[5]=1 from reset → F_power 0 through warm-up; F_power=1 when ready rises, state_dbg=10 one edge later.
6. Reset mid-fault: in FAULT with glitch_flags nonzero, rst=1 for one cycle → all flags, glitch_flags and ready 0, state_dbg=00; warm-up recounts 8 cycles.
